// File: rtl/ghr_checkpoint_unit.sv
// Speculative global-history manager for a gshare predictor.
// Keeps the speculative GHR that indexes the predictor. Each in-flight branch gets a
// checkpoint of the GHR it was predicted with, held in an in-order queue. When a branch
// resolves, the unit drives the predictor update port with that checkpoint. On a
// mispredict or a flush it repairs the speculative GHR.
module ghr_checkpoint_unit #(
    parameter int unsigned GHR_WIDTH = 13,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PTR_W     = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pred_valid_i,
    input  logic                 pred_taken_i,
    output logic                 pred_ready_o,
    output logic [GHR_WIDTH-1:0] spec_ghr_o,
    input  logic                 res_valid_i,
    input  logic                 res_taken_i,
    input  logic                 res_mispredict_i,
    input  logic                 flush_i,
    output logic                 upd_en_o,
    output logic [GHR_WIDTH-1:0] upd_ghr_o,
    output logic                 upd_taken_o,
    output logic [GHR_WIDTH-1:0] arch_ghr_o,
    output logic [PTR_W:0]       count_o
);

    localparam logic [PTR_W:0]   FullCount = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);
    localparam logic [PTR_W:0]   CntOne    = (PTR_W+1)'(1);

    logic [GHR_WIDTH-1:0] queue_q [DEPTH];

    logic [GHR_WIDTH-1:0] spec_ghr_q, spec_ghr_d;
    logic [GHR_WIDTH-1:0] arch_ghr_q, arch_ghr_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 upd_en_q, upd_en_d;
    logic [GHR_WIDTH-1:0] upd_ghr_q, upd_ghr_d;
    logic                 upd_taken_q, upd_taken_d;

    logic                 pop;
    logic                 push;
    logic                 squash;
    logic [GHR_WIDTH-1:0] pop_entry;
    logic [GHR_WIDTH-1:0] retired_ghr;

    // Decode this cycle's push and pop. Ready looks only at the current occupancy, so a
    // full queue refuses a push even while it pops.
    always_comb begin
        pred_ready_o = (count_q != FullCount);
        pop          = res_valid_i && (count_q != '0);
        pop_entry    = queue_q[rptr_q];
        retired_ghr  = {pop_entry[GHR_WIDTH-2:0], res_taken_i};
        // A flush, or a mispredicting retire, puts any same-cycle push on the wrong path.
        squash       = flush_i || (pop && res_mispredict_i);
        push         = pred_valid_i && pred_ready_o && !squash;
    end

    // Next-state logic for the history registers, pointers and update port.
    always_comb begin
        spec_ghr_d  = spec_ghr_q;
        arch_ghr_d  = arch_ghr_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        upd_en_d    = pop;
        upd_ghr_d   = upd_ghr_q;
        upd_taken_d = upd_taken_q;

        if (pop) begin
            rptr_d      = rptr_q + PtrOne;
            arch_ghr_d  = retired_ghr;
            upd_ghr_d   = pop_entry;
            upd_taken_d = res_taken_i;
        end

        if (flush_i) begin
            // Resync to the committed history, including any branch retiring right now.
            spec_ghr_d = pop ? retired_ghr : arch_ghr_q;
            count_d    = '0;
            wptr_d     = rptr_d;
        end else if (pop && res_mispredict_i) begin
            // Every younger checkpoint is on the wrong path, so drop them all.
            spec_ghr_d = retired_ghr;
            count_d    = '0;
            wptr_d     = rptr_d;
        end else begin
            if (push) begin
                wptr_d     = wptr_q + PtrOne;
                spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], pred_taken_i};
            end
            if (push && !pop) begin
                count_d = count_q + CntOne;
            end else if (!push && pop) begin
                count_d = count_q - CntOne;
            end
        end
    end

    // Control and history state; an asynchronous reset discards everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_ghr_q  <= '0;
            arch_ghr_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            upd_en_q    <= 1'b0;
            upd_ghr_q   <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            spec_ghr_q  <= spec_ghr_d;
            arch_ghr_q  <= arch_ghr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            upd_en_q    <= upd_en_d;
            upd_ghr_q   <= upd_ghr_d;
            upd_taken_q <= upd_taken_d;
        end
    end

    // Checkpoint storage holds the pre-shift GHR. Its contents need no reset because
    // the pointers and the count decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            queue_q[wptr_q] <= spec_ghr_q;
        end
    end

    assign spec_ghr_o  = spec_ghr_q;
    assign arch_ghr_o  = arch_ghr_q;
    assign count_o     = count_q;
    assign upd_en_o    = upd_en_q;
    assign upd_ghr_o   = upd_ghr_q;
    assign upd_taken_o = upd_taken_q;

endmodule

// File: tb/tb_ghr_checkpoint_unit.sv
// Self-checking bench for ghr_checkpoint_unit: async reset, a directed vector table,
// then random traffic compared against a queue-based reference model.
module tb_ghr_checkpoint_unit;

    localparam int GW = 13;
    localparam int DP = 8;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pred_valid, pred_taken, pred_ready;
    logic [GW-1:0] spec_ghr, upd_ghr, arch_ghr;
    logic          res_valid, res_taken, res_mispredict, flush;
    logic          upd_en, upd_taken;
    logic [PW:0]   count;

    int checks   = 0;
    int failures = 0;

    ghr_checkpoint_unit #(.GHR_WIDTH(GW), .DEPTH(DP), .PTR_W(PW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .pred_valid_i    (pred_valid),
        .pred_taken_i    (pred_taken),
        .pred_ready_o    (pred_ready),
        .spec_ghr_o      (spec_ghr),
        .res_valid_i     (res_valid),
        .res_taken_i     (res_taken),
        .res_mispredict_i(res_mispredict),
        .flush_i         (flush),
        .upd_en_o        (upd_en),
        .upd_ghr_o       (upd_ghr),
        .upd_taken_o     (upd_taken),
        .arch_ghr_o      (arch_ghr),
        .count_o         (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pv, pt, rv, rt, rm, fl;
        logic [GW-1:0] spec, arch;
        int            cnt;
        logic          rdy, uen;
        logic [GW-1:0] ughr;
        logic          ut;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic pt, input logic rv, input logic rt,
                       input logic rm, input logic fl, input logic [GW-1:0] sp,
                       input logic [GW-1:0] ar, input int cn, input logic rd,
                       input logic ue, input logic [GW-1:0] ug, input logic ut);
        vec_t v;
        v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt; v.rm = rm; v.fl = fl;
        v.spec = sp; v.arch = ar; v.cnt = cn; v.rdy = rd; v.uen = ue; v.ughr = ug; v.ut = ut;
        vq.push_back(v);
    endtask

    function automatic logic [GW-1:0] shl(input logic [GW-1:0] h, input logic b);
        return GW'((32'(h) * 2 + 32'(b)) % (1 << GW));
    endfunction

    task automatic drive_idle();
        pred_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0;
        res_mispredict = 0; flush = 0;
    endtask

    // Apply inputs away from the edge, clock once, sample 1 time unit after the edge.
    task automatic step(input logic pv, input logic pt, input logic rv, input logic rt,
                        input logic rm, input logic fl);
        @(negedge clk);
        pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
        res_mispredict = rm; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1 rst_n = 1;
    endtask

    // Reference model state
    logic [GW-1:0] mq[$];
    logic [GW-1:0] m_spec, m_arch, m_ughr, e;
    logic          m_uen, m_ut, m_rdy, m_pop;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        drive_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // Build some state, then hit reset mid-cycle with a push still pending.
        repeat (3) step(1, 1, 0, 0, 0, 0);
        check("pre_reset_spec", 32'(spec_ghr), 32'h007);
        check("pre_reset_count", 32'(count), 32'd3);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_spec", 32'(spec_ghr), 32'h0);
        check("rst_arch", 32'(arch_ghr), 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(pred_ready), 32'd1);
        check("rst_upd_en", 32'(upd_en), 32'd0);
        check("rst_upd_ghr", 32'(upd_ghr), 32'h0);
        #1 rst_n = 1;
        drive_idle();
        #1;
        check("post_rst_spec", 32'(spec_ghr), 32'h0);
        check("post_rst_count", 32'(count), 32'd0);

        // pv pt rv rt rm fl | spec arch cnt rdy uen ughr ut
        // Correct path: push T,T,F,T then resolve 1,1,0,1.
        add(1, 1, 0, 0, 0, 0, 13'h001, 13'h000, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h003, 13'h000, 2, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 13'h006, 13'h000, 3, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h00D, 13'h000, 4, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 13'h00D, 13'h001, 3, 1, 1, 13'h000, 1);
        add(0, 0, 1, 1, 0, 0, 13'h00D, 13'h003, 2, 1, 1, 13'h001, 1);
        add(0, 0, 1, 0, 0, 0, 13'h00D, 13'h006, 1, 1, 1, 13'h003, 0);
        add(0, 0, 1, 1, 0, 0, 13'h00D, 13'h00D, 0, 1, 1, 13'h006, 1);
        // Fill all 8 entries with takens; MSBs fall off the top.
        add(1, 1, 0, 0, 0, 0, 13'h01B, 13'h00D, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h037, 13'h00D, 2, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h06F, 13'h00D, 3, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h0DF, 13'h00D, 4, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h1BF, 13'h00D, 5, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h37F, 13'h00D, 6, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h6FF, 13'h00D, 7, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'hDFF, 13'h00D, 8, 0, 0, 0, 0);
        // Push while full with a same-cycle pop: push refused, pop retires.
        add(1, 1, 1, 1, 0, 0, 13'hDFF, 13'h01B, 7, 1, 1, 13'h00D, 1);
        // Next push lands in the wrapped slot.
        add(1, 1, 0, 0, 0, 0, 13'h1BFF, 13'h01B, 8, 0, 0, 0, 0);
        // Flush alone with a full queue.
        add(0, 0, 0, 0, 0, 1, 13'h01B, 13'h01B, 0, 1, 0, 0, 0);
        // Mispredict with a same-cycle push that must be dropped.
        add(1, 1, 0, 0, 0, 0, 13'h037, 13'h01B, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h06F, 13'h01B, 2, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h0DF, 13'h01B, 3, 1, 0, 0, 0);
        add(1, 1, 1, 0, 1, 0, 13'h036, 13'h036, 0, 1, 1, 13'h01B, 0);
        // Flush alone.
        add(1, 1, 0, 0, 0, 0, 13'h06D, 13'h036, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 13'h0DB, 13'h036, 2, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 13'h036, 13'h036, 0, 1, 0, 0, 0);
        // Flush together with a retiring pop (mispredict flag ignored, push dropped).
        add(1, 1, 0, 0, 0, 0, 13'h06D, 13'h036, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 1, 1, 13'h06D, 13'h06D, 0, 1, 1, 13'h036, 1);
        // Resolve on an empty queue is ignored.
        add(0, 0, 1, 1, 1, 0, 13'h06D, 13'h06D, 0, 1, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].pv, vq[i].pt, vq[i].rv, vq[i].rt, vq[i].rm, vq[i].fl);
            check($sformatf("vec%0d_spec", i), 32'(spec_ghr), 32'(vq[i].spec));
            check($sformatf("vec%0d_arch", i), 32'(arch_ghr), 32'(vq[i].arch));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vq[i].cnt));
            check($sformatf("vec%0d_ready", i), 32'(pred_ready), 32'(vq[i].rdy));
            check($sformatf("vec%0d_upd_en", i), 32'(upd_en), 32'(vq[i].uen));
            if (vq[i].uen) begin
                check($sformatf("vec%0d_upd_ghr", i), 32'(upd_ghr), 32'(vq[i].ughr));
                check($sformatf("vec%0d_upd_taken", i), 32'(upd_taken), 32'(vq[i].ut));
            end
        end

        // Random traffic against the queue model.
        drive_idle();
        async_reset();
        mq.delete();
        m_spec = '0; m_arch = '0; m_uen = 0; m_ughr = '0; m_ut = 0;
        for (int n = 0; n < 3000; n++) begin
            logic pv, pt, rv, rt, rm, fl;
            pv = ($urandom_range(0, 99) < 60);
            pt = $urandom_range(0, 1);
            rv = ($urandom_range(0, 99) < 45);
            rt = $urandom_range(0, 1);
            rm = ($urandom_range(0, 99) < 10);
            fl = ($urandom_range(0, 99) < 3);

            m_rdy = (mq.size() != DP);
            m_pop = rv && (mq.size() != 0);
            m_uen = m_pop;
            if (m_pop) begin
                e = mq.pop_front();
                m_arch = shl(e, rt);
                m_ughr = e;
                m_ut = rt;
            end
            if (fl) begin
                mq.delete();
                m_spec = m_arch;
            end else if (m_pop && rm) begin
                mq.delete();
                m_spec = m_arch;
            end else if (pv && m_rdy) begin
                mq.push_back(m_spec);
                m_spec = shl(m_spec, pt);
            end

            step(pv, pt, rv, rt, rm, fl);
            check($sformatf("rnd%0d_spec", n), 32'(spec_ghr), 32'(m_spec));
            check($sformatf("rnd%0d_arch", n), 32'(arch_ghr), 32'(m_arch));
            check($sformatf("rnd%0d_count", n), 32'(count), 32'(mq.size()));
            check($sformatf("rnd%0d_ready", n), 32'(pred_ready), 32'(mq.size() != DP));
            check($sformatf("rnd%0d_upd_en", n), 32'(upd_en), 32'(m_uen));
            if (m_uen) begin
                check($sformatf("rnd%0d_upd_ghr", n), 32'(upd_ghr), 32'(m_ughr));
                check($sformatf("rnd%0d_upd_taken", n), 32'(upd_taken), 32'(m_ut));
            end
        end

        drive_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
